// File: rtl/calc_ctrl.sv
// ---------------------------------------------------------------------------
// calc_ctrl -- calculator sequencing controller
//
// Consumes one-cycle key strobes from the matrix keyboard scanner, assembles
// two decimal operands, latches an operator and evaluates the expression.
// Add, subtract and multiply complete in a single calculation cycle; divide
// runs on a restoring divider that produces one quotient bit per cycle.
//
// Key map (key_pulse bit index):
//   0-9 digits, 10 '+', 11 '-', 12 '*', 13 '/', 14 '=', 15 'C'
//   A cycle with zero or with more than one bit set carries no key.
//
// Build option:
//   CALC_DIV_EN  defined   -> divider datapath present, '/' key accepted.
//                undefined -> no divider logic; key 13 behaves as no key.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   key_pulse  in   [15:0] one-hot single-cycle key strobe
//   disp_val   out  [RW-1:0] signed value to display
//   state_o    out  [2:0] current state (A=0 OP=1 B=2 CALC=3 RES=4 ERR=5)
//   busy       out  calculation in progress
//   res_valid  out  one-cycle pulse when a new result is loaded
//   err        out  divide-by-zero indication, held until 'C'
// ---------------------------------------------------------------------------
module calc_ctrl #(
    parameter int MAX_DIGITS = 4,
    parameter int OPW        = 14,
    parameter int RW         = 28
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [15:0]          key_pulse,
    output logic signed [RW-1:0] disp_val,
    output logic [2:0]           state_o,
    output logic                 busy,
    output logic                 res_valid,
    output logic                 err
);

    localparam int MAX_VAL = 10**MAX_DIGITS - 1;
    localparam int CW      = $clog2(MAX_DIGITS + 1);

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_OP   = 3'd1,
        S_B    = 3'd2,
        S_CALC = 3'd3,
        S_RES  = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } op_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t                 state_q, state_d;
    op_t                    op_q, op_d;
    logic [OPW-1:0]         opa_q, opa_d;
    logic [OPW-1:0]         opb_q, opb_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic signed [RW-1:0]   disp_q, disp_d;
    logic                   busy_q, busy_d;
    logic                   res_valid_q, res_valid_d;
    logic                   err_q, err_d;

`ifdef CALC_DIV_EN
    localparam int DCW = $clog2(OPW + 1);
    logic [OPW-1:0]         rem_q, rem_d;
    logic [OPW-1:0]         quo_q, quo_d;
    logic [DCW-1:0]         dcnt_q, dcnt_d;
`endif

    // ------------------------------------------------------------------
    // Key decode
    // ------------------------------------------------------------------
    logic [15:0] key_m;
    logic        key_ok;
    logic [3:0]  key_idx;
    logic        is_digit;
    logic        is_op;
    logic        is_eq;
    logic        is_clr;
    op_t         op_key;

    always_comb begin
        key_m = key_pulse;
`ifndef CALC_DIV_EN
        // Without the divider the '/' key simply does not exist.
        key_m[13] = 1'b0;
`endif
        // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
        key_ok  = (key_m != 16'd0) && ((key_m & (key_m - 16'd1)) == 16'd0);
        key_idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (key_m[i]) begin
                key_idx = 4'(i);
            end
        end
        is_digit = key_ok && (key_idx <= 4'd9);
        is_op    = key_ok && (key_idx >= 4'd10) && (key_idx <= 4'd13);
        is_eq    = key_ok && (key_idx == 4'd14);
        is_clr   = key_ok && (key_idx == 4'd15);
        // Keys 10..13 map onto ADD, SUB, MUL, DIV in order.
        op_key   = op_t'(2'(key_idx - 4'd10));
    end

    // ------------------------------------------------------------------
    // Decimal digit accumulation for whichever operand is being entered
    // ------------------------------------------------------------------
    logic [OPW-1:0] ent_val;
    logic [OPW-1:0] ent_new_val;
    logic [CW-1:0]  ent_new_cnt;

    always_comb begin
        ent_val     = (state_q == S_B) ? opb_q : opa_q;
        ent_new_val = ent_val;
        ent_new_cnt = cnt_q;
        // Leading zeros neither change the value nor use up a digit slot.
        if ((cnt_q < CW'(MAX_DIGITS)) && !((key_idx == 4'd0) && (ent_val == '0))) begin
            ent_new_val = ent_val * OPW'(10) + OPW'(key_idx);
            ent_new_cnt = cnt_q + CW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Single-cycle arithmetic (operands are unsigned, result signed)
    // ------------------------------------------------------------------
    logic signed [RW-1:0] a_ext;
    logic signed [RW-1:0] b_ext;
    logic signed [RW-1:0] alu_res;
    logic                 chain_ok;

    always_comb begin
        a_ext = RW'(opa_q);
        b_ext = RW'(opb_q);
        case (op_q)
            OP_ADD:  alu_res = a_ext + b_ext;
            OP_SUB:  alu_res = a_ext - b_ext;
            OP_MUL:  alu_res = a_ext * b_ext;
            default: alu_res = a_ext + b_ext;
        endcase
        // A result may seed the next operand only if it fits a legal operand.
        chain_ok = !disp_q[RW-1] && (disp_q <= RW'(MAX_VAL));
    end

    // ------------------------------------------------------------------
    // Restoring divider step
    // ------------------------------------------------------------------
    logic do_div;

`ifdef CALC_DIV_EN
    logic [OPW:0]   rem_sh;
    logic [OPW:0]   trial;
    logic [OPW-1:0] rem_step;
    logic [OPW-1:0] quo_step;

    always_comb begin
        do_div = (op_q == OP_DIV);
        // Shift the next dividend bit into the partial remainder, then try
        // to subtract the divisor; a non-negative difference yields a 1.
        rem_sh = {rem_q, quo_q[OPW-1]};
        trial  = rem_sh - {1'b0, opb_q};
        if (!trial[OPW]) begin
            rem_step = trial[OPW-1:0];
            quo_step = {quo_q[OPW-2:0], 1'b1};
        end else begin
            rem_step = rem_sh[OPW-1:0];
            quo_step = {quo_q[OPW-2:0], 1'b0};
        end
    end
`else
    assign do_div = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        cnt_d       = cnt_q;
        disp_d      = disp_q;
        busy_d      = busy_q;
        res_valid_d = 1'b0;
        err_d       = err_q;
`ifdef CALC_DIV_EN
        rem_d       = rem_q;
        quo_d       = quo_q;
        dcnt_d      = dcnt_q;
`endif

        if (is_clr) begin
            // 'C' wins in every state, including mid-calculation and error.
            state_d = S_A;
            op_d    = OP_ADD;
            opa_d   = '0;
            opb_d   = '0;
            cnt_d   = '0;
            disp_d  = '0;
            busy_d  = 1'b0;
            err_d   = 1'b0;
`ifdef CALC_DIV_EN
            rem_d   = '0;
            quo_d   = '0;
            dcnt_d  = '0;
`endif
        end else begin
            case (state_q)
                S_A: begin
                    if (is_digit) begin
                        opa_d  = ent_new_val;
                        cnt_d  = ent_new_cnt;
                        disp_d = RW'(ent_new_val);
                    end else if (is_op) begin
                        op_d    = op_key;
                        state_d = S_OP;
                    end
                end

                S_OP: begin
                    if (is_op) begin
                        op_d = op_key;
                    end else if (is_digit) begin
                        opb_d   = OPW'(key_idx);
                        cnt_d   = CW'(key_idx != 4'd0);
                        disp_d  = RW'(key_idx);
                        state_d = S_B;
                    end
                end

                S_B: begin
                    if (is_digit) begin
                        opb_d  = ent_new_val;
                        cnt_d  = ent_new_cnt;
                        disp_d = RW'(ent_new_val);
                    end else if (is_eq) begin
                        state_d = S_CALC;
                        busy_d  = 1'b1;
`ifdef CALC_DIV_EN
                        dcnt_d  = '0;
`endif
                    end
                end

                S_CALC: begin
                    if (!do_div) begin
                        disp_d      = alu_res;
                        res_valid_d = 1'b1;
                        busy_d      = 1'b0;
                        state_d     = S_RES;
                    end else begin
`ifdef CALC_DIV_EN
                        // First cycle screens for zero and loads the dividend;
                        // the following OPW cycles each retire one quotient bit.
                        if (dcnt_q == '0) begin
                            if (opb_q == '0) begin
                                err_d   = 1'b1;
                                busy_d  = 1'b0;
                                state_d = S_ERR;
                            end else begin
                                rem_d  = '0;
                                quo_d  = opa_q;
                                dcnt_d = DCW'(1);
                            end
                        end else begin
                            rem_d = rem_step;
                            quo_d = quo_step;
                            if (dcnt_q == DCW'(OPW)) begin
                                disp_d      = RW'(quo_step);
                                res_valid_d = 1'b1;
                                busy_d      = 1'b0;
                                state_d     = S_RES;
                            end else begin
                                dcnt_d = dcnt_q + DCW'(1);
                            end
                        end
`endif
                    end
                end

                S_RES: begin
                    if (is_digit) begin
                        opa_d   = OPW'(key_idx);
                        cnt_d   = CW'(key_idx != 4'd0);
                        disp_d  = RW'(key_idx);
                        state_d = S_A;
                    end else if (is_op && chain_ok) begin
                        opa_d   = disp_q[OPW-1:0];
                        cnt_d   = '0;
                        op_d    = op_key;
                        state_d = S_OP;
                    end
                end

                S_ERR: begin
                    // Held until 'C'.
                end

                default: begin
                    state_d = S_A;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_A;
            op_q        <= OP_ADD;
            opa_q       <= '0;
            opb_q       <= '0;
            cnt_q       <= '0;
            disp_q      <= '0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
            err_q       <= 1'b0;
`ifdef CALC_DIV_EN
            rem_q       <= '0;
            quo_q       <= '0;
            dcnt_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            cnt_q       <= cnt_d;
            disp_q      <= disp_d;
            busy_q      <= busy_d;
            res_valid_q <= res_valid_d;
            err_q       <= err_d;
`ifdef CALC_DIV_EN
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dcnt_q      <= dcnt_d;
`endif
        end
    end

    assign disp_val  = disp_q;
    assign state_o   = state_q;
    assign busy      = busy_q;
    assign res_valid = res_valid_q;
    assign err       = err_q;

endmodule

// File: tb/tb_calc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_calc_ctrl -- self-checking bench for calc_ctrl
//
// A behavioural model tracks the calculator at expression level (operand
// values, pending result, cycles remaining) and is compared against every
// DUT output after each clock. Directed sequences cover the headline cases,
// then a long randomized key stream exercises everything else.
// ---------------------------------------------------------------------------
module tb_calc_ctrl;
    localparam int MAX_DIGITS = 4;
    localparam int OPW        = 14;
    localparam int RW         = 28;
    localparam int MAX_VAL    = 10**MAX_DIGITS - 1;
`ifdef CALC_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    localparam int K_ADD = 10, K_SUB = 11, K_MUL = 12, K_DIV = 13, K_EQ = 14, K_CLR = 15;

    // ---------------- clock / reset ----------------
    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [15:0]          key_pulse = '0;
    logic signed [RW-1:0] disp_val;
    logic [2:0]           state_o;
    logic                 busy;
    logic                 res_valid;
    logic                 err;

    always #5 clk = ~clk;

    calc_ctrl #(.MAX_DIGITS(MAX_DIGITS), .OPW(OPW), .RW(RW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_pulse (key_pulse),
        .disp_val  (disp_val),
        .state_o   (state_o),
        .busy      (busy),
        .res_valid (res_valid),
        .err       (err)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // ---------------- reference model ----------------
    int     m_state, m_op, m_cnt, m_left;
    longint m_a, m_b, m_disp, m_res;
    bit     m_busy, m_rv, m_err, m_res_err;

    task automatic model_reset();
        m_state = 0; m_op = 0; m_cnt = 0; m_left = 0;
        m_a = 0; m_b = 0; m_disp = 0; m_res = 0;
        m_busy = 0; m_rv = 0; m_err = 0; m_res_err = 0;
    endtask

    task automatic enter(inout longint v, input int d);
        if (m_cnt < MAX_DIGITS && !(d == 0 && v == 0)) begin
            v = v * 10 + d;
            m_cnt++;
        end
    endtask

    // Work out the answer up front; m_left is clock edges until it appears.
    task automatic start_calc();
        m_res_err = 0;
        m_left    = 1;
        case (m_op)
            0: m_res = m_a + m_b;
            1: m_res = m_a - m_b;
            2: m_res = m_a * m_b;
            default: begin
                if (m_b == 0) m_res_err = 1;
                else begin
                    m_res  = m_a / m_b;
                    m_left = OPW + 1;
                end
            end
        endcase
    endtask

    task automatic model_step(input logic [15:0] k);
        logic [15:0] kk;
        int idx;
        bit one;
        kk = k;
        if (!DIV_EN) kk[13] = 1'b0;
        one = ($countones(kk) == 1);
        idx = -1;
        for (int i = 0; i < 16; i++) if (kk[i]) idx = i;
        m_rv = 0;
        if (one && idx == K_CLR) begin
            model_reset();
            return;
        end
        if (m_state == 3) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 0;
                if (m_res_err) begin
                    m_state = 5; m_err = 1;
                end else begin
                    m_disp = m_res; m_rv = 1; m_state = 4;
                end
            end
            return;
        end
        if (!one) return;
        case (m_state)
            0: if (idx <= 9) begin enter(m_a, idx); m_disp = m_a; end
               else if (idx <= K_DIV) begin m_op = idx - 10; m_state = 1; end
            1: if (idx <= 9) begin m_b = idx; m_cnt = (idx != 0); m_disp = m_b; m_state = 2; end
               else if (idx <= K_DIV) m_op = idx - 10;
            2: if (idx <= 9) begin enter(m_b, idx); m_disp = m_b; end
               else if (idx == K_EQ) begin m_state = 3; m_busy = 1; start_calc(); end
            4: if (idx <= 9) begin m_a = idx; m_cnt = (idx != 0); m_disp = m_a; m_state = 0; end
               else if (idx <= K_DIV && m_disp >= 0 && m_disp <= MAX_VAL) begin
                   m_a = m_disp; m_op = idx - 10; m_state = 1;
               end
            default: ;
        endcase
    endtask

    task automatic compare_all();
        check("disp_val",  disp_val,  m_disp);
        check("state_o",   state_o,   m_state);
        check("busy",      busy,      m_busy);
        check("res_valid", res_valid, m_rv);
        check("err",       err,       m_err);
    endtask

    // ---------------- driver ----------------
    function automatic logic [15:0] kp(input int idx);
        logic [15:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Drive one key for one clock, advance the model, sample at negedge.
    task automatic step(input logic [15:0] k);
        key_pulse = k;
        @(posedge clk);
        model_step(k);
        @(negedge clk);
        key_pulse = '0;
        compare_all();
    endtask

    task automatic press(input int idx);
        step(kp(idx));
    endtask

    logic [RW-1:0] raw;

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        rst_n = 1'b1;

        // 12 + 34 = 46
        press(1); press(2);
        check("entry_12", disp_val, 12);
        press(K_ADD); press(3); press(4);
        check("entry_34", disp_val, 34);
        press(K_EQ);
        check("eq_busy_t1", busy, 1);
        step('0);
        check("sum_46", disp_val, 46);
        check("sum_rv", res_valid, 1);
        check("sum_state", state_o, 4);
        step('0);
        check("sum_rv_drop", res_valid, 0);

        // 5 - 9 = -4
        press(K_CLR); press(5); press(K_SUB); press(9); press(K_EQ); step('0);
        check("sub_neg", disp_val, -4);
        raw = disp_val;
        check("sub_bits", raw, 28'hFFFFFFC);

        // fifth digit ignored, leading zeros free
        press(K_CLR); press(1); press(2); press(3); press(4); press(5);
        check("five_digits", disp_val, 1234);
        press(K_CLR); press(0); press(0); press(1); press(2); press(3); press(4); press(5);
        check("lead_zero", disp_val, 1234);

        // 9999 * 9999
        press(K_CLR);
        repeat (4) press(9);
        press(K_MUL);
        repeat (4) press(9);
        press(K_EQ); step('0);
        check("mul_max", disp_val, 99980001);
        check("mul_err", err, 0);

        // multi-key cycle ignored
        press(K_CLR); press(1); step(16'h0003);
        check("multi_key", disp_val, 1);

        // chaining 6*7=42, +8 = 50
        press(K_CLR); press(6); press(K_MUL); press(7); press(K_EQ); step('0);
        press(K_ADD); press(8); press(K_EQ); step('0);
        check("chain_50", disp_val, 50);

        // negative result cannot chain
        press(K_CLR); press(2); press(K_SUB); press(5); press(K_EQ); step('0);
        press(K_ADD);
        check("no_chain_neg", state_o, 4);

`ifdef CALC_DIV_EN
        // 100 / 7 = 14 after OPW+1 busy cycles
        press(K_CLR); press(1); press(0); press(0); press(K_DIV); press(7); press(K_EQ);
        check("div_busy_1", busy, 1);
        for (int i = 2; i <= OPW + 1; i++) begin
            step('0);
            check("div_busy", busy, 1);
        end
        step('0);
        check("div_q14", disp_val, 14);
        check("div_rv", res_valid, 1);

        // abort mid-division
        press(K_CLR); press(9); press(K_DIV); press(3); press(K_EQ); step('0); step('0);
        press(K_CLR);
        check("abort_busy", busy, 0);
        check("abort_rv", res_valid, 0);
        step('0);

        // divide by zero
        press(K_CLR); press(3); press(K_DIV); press(0); press(K_EQ); step('0);
        check("dz_err", err, 1);
        check("dz_state", state_o, 5);
        press(5); press(K_EQ);
        check("dz_hold", state_o, 5);
        press(K_CLR);
        check("dz_clr_err", err, 0);
        check("dz_clr_disp", disp_val, 0);
`else
        // '/' behaves as no key
        press(K_CLR); press(8); press(K_DIV);
        check("nodiv_state", state_o, 0);
`endif

        // randomized key stream
        press(K_CLR);
        for (int n = 0; n < 4000; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 50)      press($urandom_range(0, 9));
            else if (r < 68) press($urandom_range(10, 13));
            else if (r < 80) press(K_EQ);
            else if (r < 83) press(K_CLR);
            else if (r < 95) step('0);
            else             step(16'($urandom_range(0, 65535)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
